// File: rtl/fsm_sequence_checker.sv
// Receive-side checker for the cyclic LED sequence 1111 -> 1010 -> 0101 -> 0000 -> 1110.
// Optional macro SEQ_CHECK_HOLD_EN: a repeat of the last accepted pattern is ignored once tracking.
module fsm_sequence_checker #(
  parameter int LOCK_CNT = 5,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       in_pattern,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic             cycle_done,
  output logic [3:0]       exp_pattern
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0]       LOCK_THR = 8'(LOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t     state_r;
  logic [2:0] idx_r;
  logic [7:0] run_r;

  logic       tracking_s;
  logic       match_s;
  logic       hold_s;
  logic [2:0] idx_nxt_s;
  logic [7:0] run_nxt_s;

  function automatic logic [3:0] seq_at(input logic [2:0] i);
    logic [3:0] p;
    case (i)
      3'd0:    p = 4'b1111;
      3'd1:    p = 4'b1010;
      3'd2:    p = 4'b0101;
      3'd3:    p = 4'b0000;
      3'd4:    p = 4'b1110;
      default: p = 4'b1111;
    endcase
    return p;
  endfunction

  // Match/hold decode and the advanced index/run for an accepted sample.
  always_comb begin
    tracking_s = (state_r != HUNT);
    match_s    = (in_pattern == seq_at(idx_r));
    if (idx_r >= 3'd4) begin
      idx_nxt_s = 3'd0;
    end else begin
      idx_nxt_s = idx_r + 3'd1;
    end
    if (run_r >= LOCK_THR) begin
      run_nxt_s = run_r;
    end else begin
      run_nxt_s = run_r + 8'd1;
    end
`ifdef SEQ_CHECK_HOLD_EN
    // While tracking, the last accepted pattern is always the one before SEQ[idx].
    if (idx_r == 3'd0) begin
      hold_s = (in_pattern == seq_at(3'd4));
    end else begin
      hold_s = (in_pattern == seq_at(idx_r - 3'd1));
    end
`else
    hold_s = 1'b0;
`endif
  end

  // Sequence FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= HUNT;
      idx_r       <= 3'd0;
      run_r       <= 8'd0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      err_count   <= {CNT_W{1'b0}};
      cycle_done  <= 1'b0;
      exp_pattern <= 4'b1111;
    end else begin
      err_pulse  <= 1'b0;
      cycle_done <= 1'b0;
      if (in_valid && !(tracking_s && hold_s)) begin
        if (tracking_s && match_s) begin
          idx_r       <= idx_nxt_s;
          run_r       <= run_nxt_s;
          exp_pattern <= seq_at(idx_nxt_s);
          if (run_nxt_s >= LOCK_THR) begin
            state_r    <= LOCKED;
            locked     <= 1'b1;
            cycle_done <= (in_pattern == 4'b1110);
          end else begin
            state_r <= TRACK;
            locked  <= 1'b0;
          end
        end else begin
          if (state_r == LOCKED) begin
            err_pulse <= 1'b1;
            if (err_count != CNT_MAX) begin
              err_count <= err_count + CNT_ONE;
            end
          end
          // Restart: a 1111 is itself the first correct sample of a new run.
          if (in_pattern == 4'b1111) begin
            idx_r       <= 3'd1;
            run_r       <= 8'd1;
            exp_pattern <= 4'b1010;
            if (LOCK_THR <= 8'd1) begin
              state_r <= LOCKED;
              locked  <= 1'b1;
            end else begin
              state_r <= TRACK;
              locked  <= 1'b0;
            end
          end else begin
            state_r     <= HUNT;
            idx_r       <= 3'd0;
            run_r       <= 8'd0;
            locked      <= 1'b0;
            exp_pattern <= 4'b1111;
          end
        end
      end
    end
  end

endmodule
